imem_loader: RTL and testbench

- Program loader: the write side of the instruction memory that the single-cycle datapath reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words to sequential instruction-memory addresses from 0 and verifies an XOR checksum.
- Holds the CPU in reset while loading; releases it only after a clean load.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 34 +++
 rtl/imem_word_packer.sv | 37 +++
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Loader side: consumes bytes, drives the memory write port.
    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // Host side: supplies bytes, observes the memory writes.
    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word shift register with byte index and word-complete flag.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          shift_i,
    input  logic [7:0]                    byte_i,
    output logic [BYTES_PER_WORD*8-1:0]   word_o,
    output logic                          last_o
);

    logic [BYTES_PER_WORD*8-1:0] word_q;
    logic [1:0]                  idx_q;

    // word_o is the word as it stands once byte_i is shifted in, so the top can register it
    // on the same edge as the final byte transfer.
    always_comb begin
        word_o = {word_q[BYTES_PER_WORD*8-9:0], byte_i};
        last_o = shift_i && (idx_q == 2'(BYTES_PER_WORD - 1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clear_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (shift_i) begin
            word_q <= word_o;
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: length-prefixed byte stream to sequential instruction-memory words, with
// XOR checksum and CPU reset hold until a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          error
);

    state_e              state_q;
    logic                byte_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                cpu_rst_n_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [7:0]          xor_q;

    logic                xfer;
    logic                load_start;
    logic                pack_shift;
    logic                pack_last;
    logic [BYTES_PER_WORD*8-1:0] pack_word;
    logic [LEN_W-1:0]    len_next;
    logic [LEN_W-1:0]    cnt_inc;

    always_comb begin
        xfer       = bus.byte_valid && byte_ready_q;
        load_start = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
        pack_shift = xfer && (state_q == StData);
        len_next   = {len_q[LEN_W-1:8], bus.byte_data};
        cnt_inc    = cnt_q + LEN_W'(1);
    end

    imem_word_packer u_packer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (load_start),
        .shift_i (pack_shift),
        .byte_i  (bus.byte_data),
        .word_o  (pack_word),
        .last_o  (pack_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            xor_q        <= '0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (load_start) begin
                        state_q      <= StLenHi;
                        byte_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        cpu_rst_n_q  <= 1'b0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        cnt_q        <= '0;
                        xor_q        <= '0;
                    end
                end
                StLenHi: begin
                    if (xfer) begin
                        len_q[LEN_W-1:8] <= bus.byte_data;
                        state_q          <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (xfer) begin
                        len_q <= len_next;
                        if (32'(len_next) > DEPTH) begin
                            state_q      <= StErr;
                            byte_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            error_q      <= 1'b1;
                        end else if (len_next == '0) begin
                            state_q <= StCsum;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        xor_q <= xor_q ^ bus.byte_data;
                        // Counter advances on the same edge the write is registered, so the
                        // write cycle already sits in CSUM after the final word.
                        if (pack_last) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ADDR_W'(cnt_q);
                            mem_wdata_q <= DATA_W'(pack_word);
                            cnt_q       <= cnt_inc;
                            if (cnt_inc == len_q) begin
                                state_q <= StCsum;
                            end
                        end
                    end
                end
                StCsum: begin
                    if (xfer) begin
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        if (bus.byte_data == xor_q) begin
                            state_q     <= StDone;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else begin
                            state_q <= StErr;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    byte_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_rst_n      = cpu_rst_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad loads, length limits, full depth, reset mid-load.
module tb_imem_loader;

    logic clk;
    logic reset;
    logic start;
    logic cpu_rst_n;
    logic busy;
    logic done;
    logic error;

    int n_cmp;
    int n_bad;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    imem_loader #(
        .ADDR_W (8),
        .DATA_W (32),
        .DEPTH  (256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
        end
    end

    task automatic apply_reset();
        reset          = 1'b0;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns at posedge+1 after the byte's transfer edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit got;
        got = 1'b0;
        for (int i = 0; i < int'(gap); i++) begin
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte_timeout: byte_ready=%b required 1", bus.byte_ready);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({bus.byte_ready, bus.mem_we, busy, done, error, cpu_rst_n} !== 6'b000000) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy/we/busy/done/err/rstn=%b required 000000",
                     {bus.byte_ready, bus.mem_we, busy, done, error, cpu_rst_n});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata} !== 40'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got addr=%h wdata=%h required 00/00000000",
                     bus.mem_addr, bus.mem_wdata);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        n_cmp++;
        if (bus.byte_ready !== 1'b0 || wr_addr.size() != 0) begin
            n_bad++;
            $display("FAIL idle_valid: got ready=%b writes=%0d required 0/0",
                     bus.byte_ready, wr_addr.size());
        end
    endtask

    task automatic run_two_word(input logic [7:0] csum);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL start_busy: got busy=%b rstn=%b required 1/0", busy, cpu_rst_n);
        end
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        n_cmp++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h20080005) begin
            n_bad++;
            $display("FAIL write0_latency: got we=%b addr=%h data=%h required 1/00/20080005",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        send_byte(8'h00, 0);
        send_byte(8'h85, 0);
        send_byte(8'h20, 0);
        send_byte(8'h20, 0);
        n_cmp++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h01 || bus.mem_wdata !== 32'h00852020) begin
            n_bad++;
            $display("FAIL write1_latency: got we=%b addr=%h data=%h required 1/01/00852020",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        send_byte(csum, 0);
        n_cmp++;
        if (wr_addr.size() != 2) begin
            n_bad++;
            $display("FAIL two_word_count: got %0d writes required 2", wr_addr.size());
        end
    endtask

    task automatic test_load_good();
        // XOR of 20 08 00 05 00 85 20 20 is A8.
        run_two_word(8'hA8);
        n_cmp++;
        if ({done, error, cpu_rst_n, busy} !== 4'b1010) begin
            n_bad++;
            $display("FAIL good_status: got done/err/rstn/busy=%b required 1010",
                     {done, error, cpu_rst_n, busy});
        end
        n_cmp++;
        if (bus.byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL good_ready: got %b required 0", bus.byte_ready);
        end
    endtask

    task automatic test_bad_csum();
        run_two_word(8'hA9);
        n_cmp++;
        if ({done, error, cpu_rst_n, busy} !== 4'b0100) begin
            n_bad++;
            $display("FAIL bad_csum_status: got done/err/rstn/busy=%b required 0100",
                     {done, error, cpu_rst_n, busy});
        end
    endtask

    task automatic test_len_too_big();
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        n_cmp++;
        if ({error, done, busy, bus.byte_ready} !== 4'b1000) begin
            n_bad++;
            $display("FAIL len_257: got err/done/busy/rdy=%b required 1000",
                     {error, done, busy, bus.byte_ready});
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_addr.size() != 0 || cpu_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL len_257_writes: got writes=%0d rstn=%b required 0/0",
                     wr_addr.size(), cpu_rst_n);
        end
    endtask

    task automatic test_len_zero();
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n_cmp++;
        if ({done, error, cpu_rst_n} !== 3'b101 || wr_addr.size() != 0) begin
            n_bad++;
            $display("FAIL len_zero: got done/err/rstn=%b writes=%0d required 101/0",
                     {done, error, cpu_rst_n}, wr_addr.size());
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] exp_w[256];
        logic [7:0]  x;
        logic [7:0]  iv;
        logic [31:0] w;
        x = 8'h00;
        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < 256; i++) begin
            iv = i[7:0];
            exp_w[i] = {iv, ~iv, 8'hA5, iv ^ 8'h3C};
        end
        pulse_start();
        send_byte(8'h01, $urandom_range(0, 1));
        send_byte(8'h00, $urandom_range(0, 1));
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                pulse_start();
                n_cmp++;
                if (busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL start_while_busy: got busy=%b ready=%b required 1/1",
                             busy, bus.byte_ready);
                end
            end
            w = exp_w[i];
            for (int b = 3; b >= 0; b--) begin
                x = x ^ w[b*8 +: 8];
                send_byte(w[b*8 +: 8], $urandom_range(0, 1));
            end
        end
        send_byte(x, $urandom_range(0, 1));
        n_cmp++;
        if (wr_addr.size() != 256) begin
            n_bad++;
            $display("FAIL full_count: got %0d writes required 256", wr_addr.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                n_cmp++;
                if (wr_addr[i] !== i[7:0] || wr_data[i] !== exp_w[i]) begin
                    n_bad++;
                    $display("FAIL full_word[%0d]: got addr=%h data=%h required %h/%h",
                             i, wr_addr[i], wr_data[i], i[7:0], exp_w[i]);
                end
            end
        end
        n_cmp++;
        if ({done, error, cpu_rst_n} !== 3'b101) begin
            n_bad++;
            $display("FAIL full_status: got done/err/rstn=%b required 101",
                     {done, error, cpu_rst_n});
        end
    endtask

    task automatic test_reset_mid();
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        // Fourth byte of the second word and reset land on the same edge.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h88;
        reset          = 1'b0;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        n_cmp++;
        if (bus.mem_we !== 1'b0 || busy !== 1'b0 || cpu_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_abort: got we=%b busy=%b rstn=%b required 0/0/0",
                     bus.mem_we, busy, cpu_rst_n);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_cmp++;
        if (wr_addr.size() != 1 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_state: got writes=%0d addr=%h data=%h required 1/00/0",
                     wr_addr.size(), bus.mem_addr, bus.mem_wdata);
        end
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        // DE ^ AD ^ BE ^ EF = 22
        send_byte(8'h22, 0);
        n_cmp++;
        if (wr_addr.size() != 1) begin
            n_bad++;
            $display("FAIL restart_count: got %0d writes required 1", wr_addr.size());
        end else begin
            n_cmp++;
            if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDEADBEEF) begin
                n_bad++;
                $display("FAIL restart_word: got addr=%h data=%h required 00/deadbeef",
                         wr_addr[0], wr_data[0]);
            end
        end
        n_cmp++;
        if ({done, error, cpu_rst_n} !== 3'b101) begin
            n_bad++;
            $display("FAIL restart_status: got done/err/rstn=%b required 101",
                     {done, error, cpu_rst_n});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_load_good();
        test_bad_csum();
        test_len_too_big();
        test_len_zero();
        test_full_depth();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
